// File: rtl/servo_pkg.sv
// Shared constants, width helpers and position arithmetic for the servo pulse generators.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package servo_pkg;

    localparam int DEF_NUM_CH      = 8;
    localparam int DEF_POS_W       = 10;
    localparam int DEF_TICK_DIV    = 50;
    localparam int DEF_FRAME_TICKS = 20000;
    localparam int DEF_MIN_TICKS   = 1000;
    localparam int DEF_POS_LIMIT   = 1000;
    localparam int DEF_SLEW_STEP   = 0;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TICK_W  = cnt_width(DEF_TICK_DIV);
    localparam int FRAME_W = cnt_width(DEF_FRAME_TICKS);
    localparam int ADDR_W  = cnt_width(DEF_NUM_CH);

    // Saturate a requested position to the mechanical limit.
    function automatic int clamp_pos(input int val, input int limit);
        return (val > limit) ? limit : val;
    endfunction

    // One frame's worth of movement from cur toward tgt; step 0 jumps straight there.
    // Distances are compared before any add/subtract so the result never wraps.
    function automatic int slew_next(input int cur, input int tgt, input int step);
        if (step == 0) begin
            return tgt;
        end
        if (tgt > cur) begin
            return ((tgt - cur) <= step) ? tgt : cur + step;
        end
        return ((cur - tgt) <= step) ? tgt : cur - step;
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler plus frame tick counter; frame_start is a registered pulse on each frame's first cycle.
// Latency: counters preset to terminal values, so the first frame starts one edge after reset.
// Backpressure: none, free-running.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    localparam int TW = cnt_width(TICK_DIV),
    localparam int FW = cnt_width(FRAME_TICKS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          tick,
    output logic          wrap,
    output logic [FW-1:0] frame_cnt,
    output logic          frame_start
);

    logic [TW-1:0] presc;

    assign tick = (presc == TW'(TICK_DIV - 1));
    // wrap is high in the cycle whose closing edge starts a new frame
    assign wrap = tick && (frame_cnt == FW'(FRAME_TICKS - 1));

    // Prescaler, frame counter and the registered frame-start strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= TW'(TICK_DIV - 1);
            frame_cnt   <= FW'(FRAME_TICKS - 1);
            frame_start <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + TW'(1);
            if (tick) begin
                frame_cnt <= wrap ? '0 : frame_cnt + FW'(1);
            end
            frame_start <= wrap;
        end
    end

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo pulse generator with per-channel targets, slew limit and enable.
// Latency: writes reach the pulse at the next frame boundary (slew permitting); outputs are flops.
// Backpressure: none; writes are accepted every cycle, out-of-range addresses are dropped.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int POS_W       = DEF_POS_W,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int POS_LIMIT   = DEF_POS_LIMIT,
    parameter int SLEW_STEP   = DEF_SLEW_STEP,
    localparam int AW = cnt_width(NUM_CH),
    localparam int FW = cnt_width(FRAME_TICKS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [POS_W-1:0]  wr_data_i,
    input  logic [NUM_CH-1:0] enable_i,
    output logic              frame_start_o,
    output logic [NUM_CH-1:0] servo_pulse_o
);

    logic          tick;
    logic          wrap;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] cnt_next;

    servo_tick_gen #(
        .TICK_DIV    (TICK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick_gen (
        .clk         (clk_i),
        .reset       (reset_i),
        .tick        (tick),
        .wrap        (wrap),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start_o)
    );

    // Frame count as it will read after this edge, so pulses can be registered in step with it
    always_comb begin
        cnt_next = frame_cnt;
        if (wrap) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = frame_cnt + FW'(1);
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [POS_W-1:0] target;
        logic [POS_W-1:0] active;
        logic [POS_W-1:0] active_nxt;
        logic             en_q;
        logic             en_nxt;
        logic             pulse_q;
        logic             wr_hit;

        // Addresses beyond NUM_CH match no channel and are silently dropped
        assign wr_hit = wr_en_i && (wr_addr_i == AW'(ch));

        // Position and enable only change on the frame boundary, keeping pulses glitch-free
        always_comb begin
            active_nxt = active;
            en_nxt     = en_q;
            if (wrap) begin
                active_nxt = POS_W'(slew_next(int'(active), int'(target), SLEW_STEP));
                en_nxt     = enable_i[ch];
            end
        end

        // Channel state and registered pulse; a same-cycle write lands in target after active samples it
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                target  <= '0;
                active  <= '0;
                en_q    <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                if (wr_hit) begin
                    target <= POS_W'(clamp_pos(int'(wr_data_i), POS_LIMIT));
                end
                active  <= active_nxt;
                en_q    <= en_nxt;
                pulse_q <= en_nxt && (int'(cnt_next) < (MIN_TICKS + int'(active_nxt)));
            end
        end

        assign servo_pulse_o[ch] = pulse_q;
    end

endmodule
